dac_req_arbiter: RTL and testbench

DAC_REQ_ARBITER -- requirements
Module: dac_req_arbiter

---
 rtl/dac_req_arbiter.sv | 147 ++++++++++++++
 tb/tb_dac_req_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_req_arbiter.sv
// Round-robin arbiter that hands one requester's sample at a time to a shared SPI DAC engine.
// Each grant runs LOAD -> WAIT (synchronised done edge or timeout) -> RELEASE before rearbitrating.
module dac_req_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DW      = 12,
  parameter int unsigned TIMEOUT = 16384,
  parameter int unsigned REL_CYC = 4
) (
  input  logic                    clk100mhz,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         ack,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    err_timeout,
  output logic                    st_wrt,
  output logic [DW-1:0]           data_in,
  input  logic                    done
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned RW = (REL_CYC > 1) ? $clog2(REL_CYC) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, RELEASE} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [IW-1:0]   gid_n;
  logic [DW-1:0]   data_n;
  logic [NREQ-1:0] ack_n;
  logic            st_n, err_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [RW-1:0]   rel, rel_n;
  logic            done_s1, done_s2, done_s3;
  logic            done_rise;
  logic [IW-1:0]   pick, cand;
  logic            found;

  // done crosses from the engine domain; edge taken on the synchronised copy
  always_ff @(posedge clk100mhz or negedge rst_n) begin
    if (!rst_n) begin
      done_s1 <= 1'b0;
      done_s2 <= 1'b0;
      done_s3 <= 1'b0;
    end else begin
      done_s1 <= done;
      done_s2 <= done_s1;
      done_s3 <= done_s2;
    end
  end

  assign done_rise = done_s2 & ~done_s3;

  // First requesting index at or above the pointer, wrapping modulo NREQ
  always_comb begin
    pick  = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = ptr + IW'(k);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      grant_id    <= '0;
      data_in     <= '0;
      ack         <= '0;
      st_wrt      <= 1'b0;
      err_timeout <= 1'b0;
      busy        <= 1'b0;
      cnt         <= '0;
      rel         <= '0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      grant_id    <= gid_n;
      data_in     <= data_n;
      ack         <= ack_n;
      st_wrt      <= st_n;
      err_timeout <= err_n;
      busy        <= (state_n != IDLE);
      cnt         <= cnt_n;
      rel         <= rel_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gid_n   = grant_id;
    data_n  = data_in;
    ack_n   = '0;
    st_n    = st_wrt;
    err_n   = err_timeout;
    cnt_n   = cnt;
    rel_n   = rel;
    unique case (state)
      IDLE: begin
        st_n = 1'b0;
        if (found) begin
          gid_n   = pick;
          data_n  = req_data[32'(pick)*DW +: DW];
          state_n = LOAD;
        end
      end
      LOAD: begin
        st_n    = 1'b1;
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        // completion takes priority over a timeout landing on the same cycle
        if (done_rise) begin
          ack_n[grant_id] = 1'b1;
          st_n            = 1'b0;
          ptr_n           = grant_id + IW'(1);
          rel_n           = '0;
          state_n         = RELEASE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          st_n    = 1'b0;
          ptr_n   = grant_id + IW'(1);
          rel_n   = '0;
          state_n = RELEASE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RELEASE: begin
        st_n = 1'b0;
        if (rel == RW'(REL_CYC - 1)) state_n = IDLE;
        else                         rel_n   = rel + RW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dac_req_arbiter.sv
// Bench for dac_req_arbiter: timeline model of each grant checked every cycle, plus directed
// scenarios (round robin, long transaction, completion/timeout collision, timeout, reset, withdrawal).
module tb_dac_req_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 12;
  localparam int TIMEOUT = 16384;
  localparam int REL_CYC = 4;

  logic                 clk100mhz = 1'b0;
  logic                 rst_n     = 1'b0;
  logic [NREQ-1:0]      req       = '0;
  logic [NREQ*DW-1:0]   req_data  = '0;
  logic [NREQ-1:0]      ack;
  logic [1:0]           grant_id;
  logic                 busy, err_timeout, st_wrt;
  logic [DW-1:0]        data_in;
  logic                 done      = 1'b0;

  dac_req_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT), .REL_CYC(REL_CYC)) dut (
    .clk100mhz(clk100mhz), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
    .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout), .st_wrt(st_wrt),
    .data_in(data_in), .done(done)
  );

  initial forever #5 clk100mhz = ~clk100mhz;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk100mhz) cyc <= cyc + 1;

  // Engine stand-in: done rises eng_delay cycles after st_wrt goes high (0 = never), clears with st_wrt
  int eng_delay = 10;
  int eng_cnt   = 0;
  always @(negedge clk100mhz) begin
    if (!st_wrt) begin
      eng_cnt = 0;
      done    = 1'b0;
    end else begin
      eng_cnt++;
      if (eng_delay != 0 && eng_cnt == eng_delay) done = 1'b1;
    end
  end

  // Inputs as seen by the DUT at each rising edge
  logic [NREQ-1:0]    s_req;
  logic [NREQ*DW-1:0] s_data;
  logic               s_done;
  bit                 cap_v;
  always @(posedge clk100mhz or negedge rst_n) begin
    if (!rst_n) begin
      cap_v  <= 1'b0;
      s_req  <= '0;
      s_data <= '0;
      s_done <= 1'b0;
    end else begin
      cap_v  <= 1'b1;
      s_req  <= req;
      s_data <= req_data;
      s_done <= done;
    end
  end

  // Model: t counts edges since the grant edge, te is the edge that ended WAIT (0 = still waiting)
  bit          m_act, m_ok, m_err, h0, h1, h2, m_found, m_sedge;
  int          m_t, m_te, m_gid, m_ptr, m_i;
  logic [DW-1:0] m_data;
  logic [NREQ-1:0] e_ack;
  logic        e_st;

  task model_reset();
    m_act = 0; m_ok = 0; m_err = 0; h0 = 0; h1 = 0; h2 = 0;
    m_t = 0; m_te = 0; m_gid = 0; m_ptr = 0; m_data = '0;
  endtask

  task model_step();
    m_sedge = h1 && !h2;
    h2 = h1; h1 = h0; h0 = s_done;
    if (!m_act) begin
      if (s_req != 0) begin
        m_found = 0;
        for (int k = 0; k < NREQ; k++) begin
          m_i = (m_ptr + k) % NREQ;
          if (!m_found && s_req[m_i]) begin m_gid = m_i; m_found = 1; end
        end
        m_data = s_data[m_gid*DW +: DW];
        m_act = 1; m_t = 0; m_te = 0; m_ok = 0;
      end
    end else begin
      m_t++;
      if (m_te == 0 && m_t >= 2) begin
        if (m_sedge) begin m_te = m_t; m_ok = 1; end
        else if (m_t == TIMEOUT + 1) begin m_te = m_t; m_err = 1; end
        if (m_te != 0) m_ptr = (m_gid + 1) % NREQ;
      end else if (m_te != 0 && m_t == m_te + REL_CYC) begin
        m_act = 0;
      end
    end
  endtask

  // Grant / ack event log for the directed checks
  int              g_cyc[$];
  int              g_id[$];
  int              a_cyc[$];
  logic [NREQ-1:0] a_val[$];
  bit              busy_q = 0;

  always @(negedge clk100mhz) begin
    if (!rst_n) begin
      model_reset();
    end else if (cap_v) begin
      model_step();
      e_st  = m_act && m_t >= 1 && m_te == 0;
      e_ack = (m_act && m_ok && m_te != 0 && m_t == m_te) ? NREQ'(1 << m_gid) : '0;
      n_cmp++;
      if ({ack, grant_id, busy, err_timeout, st_wrt, data_in} !==
          {e_ack, 2'(m_gid), m_act, m_err, e_st, m_data}) begin
        n_bad++;
        $display("FAIL cycle_check @%0d: got ack=%b gid=%0d busy=%b err=%b st=%b data=%h, expected ack=%b gid=%0d busy=%b err=%b st=%b data=%h",
                 cyc, ack, grant_id, busy, err_timeout, st_wrt, data_in,
                 e_ack, m_gid, m_act, m_err, e_st, m_data);
      end
    end
    if (rst_n) begin
      if (busy && !busy_q) begin g_cyc.push_back(cyc); g_id.push_back(int'(grant_id)); end
      if (ack != 0) begin a_cyc.push_back(cyc); a_val.push_back(ack); end
    end
    busy_q = busy;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bound_expired(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired before the expected event", nm);
  endtask

  task automatic tick();
    @(negedge clk100mhz);
    #1;
  endtask

  task automatic clear_log();
    g_cyc.delete(); g_id.delete(); a_cyc.delete(); a_val.delete();
  endtask

  task automatic wait_grants(input int n, input int budget, input string nm);
    int k = 0;
    while (g_cyc.size() < n && k < budget) begin tick(); k++; end
    if (g_cyc.size() < n) bound_expired(nm);
  endtask

  task automatic wait_acks(input int n, input int budget, input string nm);
    int k = 0;
    while (a_cyc.size() < n && k < budget) begin tick(); k++; end
    if (a_cyc.size() < n) bound_expired(nm);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k = 0;
    while (busy && k < budget) begin tick(); k++; end
    if (busy) bound_expired(nm);
  endtask

  initial begin
    #900000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_rr[5];
    int cnt_bits[NREQ];
    int r, st_hi, err_cyc;
    exp_rr = '{0, 1, 2, 3, 0};

    // Reset values
    repeat (3) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_st_wrt", 32'(st_wrt), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_gid", 32'(grant_id), 0);
    check("rst_data", 32'(data_in), 0);
    check("rst_err", 32'(err_timeout), 0);

    // Round robin with all four requesting
    clear_log();
    eng_delay = 10;
    req_data  = {12'h444, 12'h333, 12'h222, 12'h111};
    req       = 4'b1111;
    rst_n     = 1'b1;
    wait_grants(5, 200, "rr_grants");
    req = 4'b0000;
    wait_acks(5, 100, "rr_acks");
    for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), 32'(g_id[i]), 32'(exp_rr[i]));
    for (int i = 0; i < 4; i++) check($sformatf("rr_spacing%0d", i), 32'(g_cyc[i+1] - g_cyc[i]), 18);
    for (int b = 0; b < NREQ; b++) cnt_bits[b] = 0;
    foreach (a_val[i]) for (int b = 0; b < NREQ; b++) if (a_val[i][b]) cnt_bits[b]++;
    check("rr_ack_bit0", 32'(cnt_bits[0]), 2);
    check("rr_ack_bit1", 32'(cnt_bits[1]), 1);
    check("rr_ack_bit2", 32'(cnt_bits[2]), 1);
    check("rr_ack_bit3", 32'(cnt_bits[3]), 1);
    wait_idle(20, "rr_idle");

    // Single long transaction from requester 2
    clear_log();
    eng_delay = 6500;
    req_data[2*DW +: DW] = 12'hAAA;
    req = 4'b0100;
    wait_grants(1, 50, "single_grant");
    check("single_st_load", 32'(st_wrt), 0);
    check("single_gid", 32'(grant_id), 2);
    check("single_data", 32'(data_in), 32'h0AAA);
    tick();
    check("single_st_wait", 32'(st_wrt), 1);
    wait_acks(1, 7000, "single_ack");
    req = 4'b0000;
    check("single_ack_val", 32'(a_val[0]), 32'h4);
    check("single_latency", 32'(a_cyc[0] - g_cyc[0]), 6503);
    r = 0; st_hi = 0;
    while (busy && r < 20) begin
      if (st_wrt) st_hi++;
      r++;
      tick();
    end
    check("single_release_len", 32'(r), 4);
    check("single_release_st", 32'(st_hi), 0);
    check("single_ack_count", 32'(a_cyc.size()), 1);

    // Completion edge lands on the final timeout cycle
    clear_log();
    eng_delay = TIMEOUT - 2;
    req_data[0 +: DW] = 12'h5A5;
    req = 4'b0001;
    wait_grants(1, 50, "coll_grant");
    wait_acks(1, 16500, "coll_ack");
    req = 4'b0000;
    check("coll_ack_val", 32'(a_val[0]), 32'h1);
    check("coll_latency", 32'(a_cyc[0] - g_cyc[0]), 16385);
    check("coll_err", 32'(err_timeout), 0);
    wait_idle(20, "coll_idle");

    // Timeout with requester 2 still pending behind requester 1
    clear_log();
    eng_delay = 0;
    req = 4'b0110;
    wait_grants(1, 50, "to_grant");
    check("to_gid", 32'(g_id[0]), 1);
    r = 0;
    while (!err_timeout && r < 16500) begin tick(); r++; end
    if (!err_timeout) bound_expired("to_err_wait");
    err_cyc = cyc;
    check("to_latency", 32'(err_cyc - g_cyc[0]), 16385);
    check("to_no_ack", 32'(a_cyc.size()), 0);
    eng_delay = 10;
    wait_grants(2, 30, "to_next_grant");
    req = 4'b0000;
    check("to_next_gid", 32'(g_id[1]), 2);
    check("to_next_spacing", 32'(g_cyc[1] - g_cyc[0]), 16390);
    wait_acks(1, 100, "to_next_ack");
    check("to_next_ack_val", 32'(a_val[0]), 32'h4);
    check("to_err_sticky", 32'(err_timeout), 1);
    wait_idle(20, "to_idle");

    // Reset in the middle of WAIT, then grant from pointer 0 and withdraw during WAIT
    clear_log();
    eng_delay = 1000;
    req_data[3*DW +: DW] = 12'hC3C;
    req = 4'b1000;
    wait_grants(1, 50, "mid_grant");
    check("mid_gid", 32'(grant_id), 3);
    repeat (50) tick();
    check("mid_st_high", 32'(st_wrt), 1);
    req = 4'b1010;
    req_data[1*DW +: DW] = 12'h1B1;
    @(posedge clk100mhz);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_st", 32'(st_wrt), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_gid", 32'(grant_id), 0);
    check("mid_rst_data", 32'(data_in), 0);
    check("mid_rst_err", 32'(err_timeout), 0);
    check("mid_rst_ack", 32'(ack), 0);
    eng_delay = 20;
    clear_log();
    tick();
    rst_n = 1'b1;
    wait_grants(1, 20, "post_rst_grant");
    check("post_rst_gid", 32'(grant_id), 1);
    check("post_rst_data", 32'(data_in), 32'h01B1);
    tick();
    tick();
    req = 4'b0000;
    req_data[1*DW +: DW] = 12'hFFF;
    wait_acks(1, 100, "wd_ack");
    check("wd_ack_val", 32'(a_val[0]), 32'h2);
    check("wd_data_hold", 32'(data_in), 32'h01B1);
    check("wd_gid_hold", 32'(grant_id), 1);
    wait_idle(20, "wd_idle");
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
